// File: rtl/mult9x9_sched_pkg.sv
// Shared widths and record types for the MULT9X9 round-robin scheduler and its response FIFO.
package mult9x9_sched_pkg;

  localparam int MULT_IN_W  = 9;
  localparam int MULT_OUT_W = 18;
  localparam int ID_W       = 3;
  localparam int RSP_W      = ID_W + MULT_OUT_W;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [MULT_OUT_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/mult9x9_rsp_fifo.sv
// Show-ahead synchronous FIFO of tagged products; head is valid whenever empty is low.
module mult9x9_rsp_fifo
  import mult9x9_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [RSP_W-1:0]       push_data,
  input  logic                   pop,
  output logic [RSP_W-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because the pointers are.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // The upstream credit scheme must never let a product arrive with no room for it.
  no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n) push |-> !full);

endmodule

// File: rtl/mult9x9_rr_sched.sv
// Round-robin sharing of one MULT9X9 among NREQ requesters with credit-gated issue and tagged responses.
// Optional statistics counters are enabled by defining MULT9X9_SCHED_STATS_EN.
module mult9x9_rr_sched
  import mult9x9_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [MULT_IN_W*NREQ-1:0]   req_a,
  input  logic [MULT_IN_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic [MULT_IN_W-1:0]        mult_a,
  output logic [MULT_IN_W-1:0]        mult_b,
  output logic                        mult_reset,
  input  logic [MULT_OUT_W-1:0]       mult_dout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [MULT_OUT_W-1:0]       rsp_data
`ifdef MULT9X9_SCHED_STATS_EN
  ,
  output logic [31:0]                 stat_issue,
  output logic [31:0]                 stat_stall
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int IW1 = IDW + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [MULT_IN_W-1:0] op_a [NREQ];
  logic [MULT_IN_W-1:0] op_b [NREQ];

  logic [IDW-1:0]    ptr_q, ptr_d, grant;
  logic [2*NREQ-1:0] dbl_req;
  logic [NREQ-1:0]   rot_req;
  logic [IW1-1:0]    g_off, g_sum;
  logic              started_q;
  tag_t              tag_q [LATENCY];
  tag_t              tag_d [LATENCY];
  int                inflight;
  logic              has_credit, issue;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, push, pop;
  rsp_t              push_data, head;
  logic              unused_head_id;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign op_a[gi] = req_a[MULT_IN_W*gi +: MULT_IN_W];
    assign op_b[gi] = req_b[MULT_IN_W*gi +: MULT_IN_W];
  end

  // Rotate the request vector so index 0 is ptr, pick the lowest set bit, then un-rotate.
  always_comb begin
    dbl_req = {req_valid, req_valid} >> ptr_q;
    rot_req = dbl_req[NREQ-1:0];
    g_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) g_off = IW1'(k);
    end
    g_sum = {1'b0, ptr_q} + g_off;
    grant = (g_sum >= IW1'(NREQ)) ? IDW'(g_sum - IW1'(NREQ)) : g_sum[IDW-1:0];
  end

  always_comb begin
    inflight = 0;
    for (int s = 0; s < LATENCY; s++) inflight += int'(tag_q[s].v);
    has_credit = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    issue      = started_q && (|req_valid) && has_credit && !flush;
    req_ready  = '0;
    mult_a     = '0;
    mult_b     = '0;
    if (issue) begin
      req_ready[grant] = 1'b1;
      mult_a           = op_a[grant];
      mult_b           = op_b[grant];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (flush)      ptr_d = '0;
    else if (issue) ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    tag_d[0].v  = issue;
    tag_d[0].id = ID_W'(grant);
    for (int s = 1; s < LATENCY; s++) tag_d[s] = tag_q[s-1];
    if (flush) begin
      for (int s = 0; s < LATENCY; s++) tag_d[s] = '0;
    end
  end

  // started_q keeps the first cycle after reset release from accepting anything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_q <= 1'b0;
      ptr_q     <= '0;
      for (int s = 0; s < LATENCY; s++) tag_q[s] <= '0;
    end else begin
      started_q <= 1'b1;
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
    end
  end

  assign push           = tag_q[LATENCY-1].v;
  assign push_data.id   = tag_q[LATENCY-1].id;
  assign push_data.data = mult_dout;
  assign pop            = rsp_valid && rsp_ready;

  mult9x9_rsp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mult_reset     = flush;
  assign rsp_valid      = !fifo_empty;
  assign rsp_id         = fifo_empty ? '0 : head.id[IDW-1:0];
  assign rsp_data       = fifo_empty ? '0 : head.data;
  assign unused_head_id = ^head.id;

`ifdef MULT9X9_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_issue_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issue_d = stat_issue_q + 32'(issue);
    stat_stall_d = stat_stall_q + 32'((|req_valid) && !issue && !flush);
    if (flush) begin
      stat_issue_d = '0;
      stat_stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_issue_q <= stat_issue_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mult9x9_rr_sched.sv
// Directed bench for mult9x9_rr_sched with a behavioural MULT9X9 (AREG/BREG + OUT_REG) and a response scoreboard.
module tb_mult9x9_rr_sched;
  import mult9x9_sched_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [35:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [8:0]  mult_a, mult_b;
  logic        mult_reset;
  logic [17:0] mult_dout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [17:0] rsp_data;
`ifdef MULT9X9_SCHED_STATS_EN
  logic [31:0] stat_issue, stat_stall;
`endif

  logic [8:0]  tb_a [NREQ];
  logic [8:0]  tb_b [NREQ];

  typedef struct packed {
    logic [1:0]  id;
    logic [17:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   accepts = 0;
  int   a_mark;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[9*i +: 9] = tb_a[i];
      req_b[9*i +: 9] = tb_b[i];
    end
  end

  // MULT9X9 stand-in: operand registers, then output register, sync reset.
  logic [8:0]  m_a_q, m_b_q;
  logic [17:0] m_p_q;
  always_ff @(posedge clk) begin
    if (mult_reset) begin
      m_a_q <= '0;
      m_b_q <= '0;
      m_p_q <= '0;
    end else begin
      m_a_q <= mult_a;
      m_b_q <= mult_b;
      m_p_q <= 18'(m_a_q) * 18'(m_b_q);
    end
  end
  assign mult_dout = m_p_q;

  mult9x9_rr_sched #(
    .NREQ(4),
    .LATENCY(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_reset (mult_reset),
    .mult_dout  (mult_dout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef MULT9X9_SCHED_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe accepts and responses at the falling edge, return just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("ready_onehot", 32'($onehot0(req_ready)), 32'(1));
    chk("ready_subset", 32'(req_ready & ~req_valid), 32'(0));
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        e.id   = 2'(i);
        e.data = 18'(tb_a[i]) * 18'(tb_b[i]);
        sb.push_back(e);
        accepts++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk(tag, 32'(sb.size()), 32'(0));
    #1;
    chk({tag, "_idle"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      tb_a[i] = '0;
      tb_b[i] = '0;
    end

    // Reset state, with a request already pending.
    tb_a[0] = 9'h123;
    tb_b[0] = 9'h0fd;
    req_valid = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_mult_a", 32'(mult_a), 32'(0));
    chk("rst_mult_b", 32'(mult_b), 32'(0));
    chk("rst_mult_reset", 32'(mult_reset), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    reset_n = 1'b1;
    #1;
    chk("first_cycle_no_accept", 32'(req_ready), 32'(0));
    step();

    // Test 1: single request, response three cycles after accept.
    #1;
    chk("t1_ready", 32'(req_ready), 32'(1));
    chk("t1_mult_a", 32'(mult_a), 32'h123);
    chk("t1_mult_b", 32'(mult_b), 32'h0fd);
    step();
    req_valid = 4'b0000;
    #1;
    chk("t1_rsp_c1", 32'(rsp_valid), 32'(0));
    step();
    #1;
    chk("t1_rsp_c2", 32'(rsp_valid), 32'(0));
    step();
    #1;
    chk("t1_rsp_c3", 32'(rsp_valid), 32'(1));
    chk("t1_rsp_id", 32'(rsp_id), 32'(0));
    chk("t1_rsp_data", 32'(rsp_data), 32'h11f97);
    step();
    #1;
    chk("t1_rsp_c4", 32'(rsp_valid), 32'(0));

    // Flush while idle brings the pointer back to 0.
    flush = 1'b1;
    #1;
    chk("flush_mult_reset", 32'(mult_reset), 32'(1));
    step();
    flush = 1'b0;

    // Test 2: all requesters held valid -> strict rotation, one response per cycle.
    tb_a[0] = 9'd2; tb_a[1] = 9'd2; tb_a[2] = 9'd4; tb_a[3] = 9'd4;
    tb_b[0] = 9'd2; tb_b[1] = 9'd2; tb_b[2] = 9'd4; tb_b[3] = 9'd4;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 3) chk("t2_rsp_stream", 32'(rsp_valid), 32'(1));
      step();
    end
    req_valid = 4'b0000;
    drain("t2_drain");

    // Test 3: consumer stalled -> exactly four accepts, then resume after first pop.
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    a_mark = accepts;
    repeat (8) step();
    chk("t3_accepts", 32'(accepts - a_mark), 32'(4));
    #1;
    chk("t3_full_ready", 32'(req_ready), 32'(0));
    chk("t3_full_valid", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    #1;
    chk("t3_pop_cycle_ready", 32'(req_ready), 32'(0));
    step();
    #1;
    chk("t3_resume_ready", 32'(req_ready), 32'(1));
    repeat (6) step();
    req_valid = 4'b0000;
    drain("t3_drain");

    // Test 4: flush discards two in-flight products and resets the pointer.
    tb_a[1] = 9'd4; tb_b[1] = 9'd5;
    tb_a[2] = 9'd4; tb_b[2] = 9'd6;
    req_valid = 4'b0010;
    #1;
    chk("t4_req1", 32'(req_ready), 32'(2));
    step();
    req_valid = 4'b0100;
    #1;
    chk("t4_req2", 32'(req_ready), 32'(4));
    step();
    flush = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t4_mult_reset", 32'(mult_reset), 32'(1));
    chk("t4_no_issue", 32'(req_ready), 32'(0));
    step();
    flush = 1'b0;
    #1;
    chk("t4_ptr_zero", 32'(req_ready), 32'(1));
    chk("t4_mult_reset_off", 32'(mult_reset), 32'(0));
    step();
    req_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_no_rsp", 32'(rsp_valid), 32'(0));
      step();
    end
    drain("t4_drain");

    // Test 5: asynchronous reset mid-stream.
    req_valid = 4'b1111;
    repeat (5) step();
    #1;
    chk("t5_pre_valid", 32'(rsp_valid), 32'(1));
    chk("t5_pre_ready", 32'(req_ready != 0), 32'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'(0));
    chk("t5_rst_ready", 32'(req_ready), 32'(0));
    chk("t5_rst_data", 32'(rsp_data), 32'(0));
    sb.delete();
    step();
    reset_n = 1'b1;
    req_valid = 4'b1000;
    tb_a[3] = 9'h1ff;
    tb_b[3] = 9'h101;
    #1;
    chk("t5_first_cycle", 32'(req_ready), 32'(0));
    step();
    #1;
    chk("t5_post_accept", 32'(req_ready), 32'(8));
    step();
    req_valid = 4'b0000;
    drain("t5_drain");

`ifdef MULT9X9_SCHED_STATS_EN
    // Test 6: statistics counters.
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t6_issue_clr", stat_issue, 32'(0));
    chk("t6_stall_clr", stat_stall, 32'(0));
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (7) step();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    drain("t6_drain_a");
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    drain("t6_drain_b");
    chk("t6_issue", stat_issue, 32'(6));
    chk("t6_stall", stat_stall, 32'(3));
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t6_issue_flush", stat_issue, 32'(0));
    chk("t6_stall_flush", stat_stall, 32'(0));
`endif

    chk("final_sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
